// File: rtl/rcvr_deser.sv
// rcvr_deser: oversampling receiver for the frame-synced 16-bit serial link.
// The three link lines are synchronised into clk. Words are assembled MSB
// first on each detected sclk falling edge and are handed to the consumer
// through a show-ahead FIFO with a valid/ready handshake.
module rcvr_deser #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_sclk,
  input  logic        i_fs,
  input  logic        i_d,
  output logic [15:0] o_rx_data,
  output logic        o_rx_vld,
  input  logic        i_rx_rdy,
  output logic        o_ovf,
  input  logic        i_ovf_clr,
  output logic [7:0]  o_err_cnt
);

  localparam int AW = $clog2(DEPTH);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_DATA = 1'b1;

  // Synchroniser chains. sclk has one extra stage for edge detection.
  logic [2:0] sclk_sync;
  logic [1:0] fs_sync;
  logic [1:0] d_sync;

  logic       sample;
  logic       fs_smp;
  logic       d_smp;

  // Receiver state
  logic        state, state_d;
  logic [3:0]  bit_cnt, bit_cnt_d;
  logic [15:0] shift, shift_d;
  logic        push;
  logic        frm_err;
  logic [15:0] word;

  // FIFO state
  logic [15:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          pop;
  logic          wr_en;
  logic          ovf_set;

  // Two-flop synchronisers on all link lines, plus the sclk history flop.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      fs_sync   <= '0;
      d_sync    <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], i_sclk};
      fs_sync   <= {fs_sync[0], i_fs};
      d_sync    <= {d_sync[0], i_d};
    end
  end

  assign sample = sclk_sync[2] & ~sclk_sync[1];
  assign fs_smp = fs_sync[1];
  assign d_smp  = d_sync[1];
  assign word   = {shift[14:0], d_smp};

  // Framing state machine: next state, bit counter, shifter, push and error strobes.
  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    shift_d   = shift;
    push      = 1'b0;
    frm_err   = 1'b0;
    if (sample) begin
      case (state)
        ST_IDLE: begin
          if (fs_smp) begin
            state_d   = ST_DATA;
            bit_cnt_d = 4'd0;
          end
        end
        default: begin
          shift_d = word;
          if (bit_cnt == 4'd15) begin
            // Last bit: fs here overlaps the next word's sync slot.
            push      = 1'b1;
            bit_cnt_d = 4'd0;
            state_d   = fs_smp ? ST_DATA : ST_IDLE;
          end else if (fs_smp) begin
            // Early fs: drop the partial word and resynchronise on this slot.
            frm_err   = 1'b1;
            bit_cnt_d = 4'd0;
          end else begin
            bit_cnt_d = bit_cnt + 4'd1;
          end
        end
      endcase
    end
  end

  // Receiver state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      bit_cnt <= 4'd0;
      shift   <= 16'd0;
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
      shift   <= shift_d;
    end
  end

  assign o_rx_vld  = (count != '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign pop       = o_rx_vld & i_rx_rdy;
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign wr_en     = push & (~full | pop);
  assign ovf_set   = push & full & ~pop;
  assign o_rx_data = mem[rd_ptr];

  // FIFO storage, pointers and occupancy.
  // NOTE: the storage is reset here only because the head word must read 0 after reset; it is a few flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 16'd0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= word;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag (set beats clear) and saturating framing error count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ovf     <= 1'b0;
      o_err_cnt <= 8'd0;
    end else begin
      if (ovf_set)        o_ovf <= 1'b1;
      else if (i_ovf_clr) o_ovf <= 1'b0;
      if (frm_err && (o_err_cnt != 8'hFF)) o_err_cnt <= o_err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_rcvr_deser.sv
// tb_rcvr_deser: directed bench for rcvr_deser. Stimulus pushes the words it
// expects into a scoreboard queue; a monitor pops and compares on every
// accepted handshake and checks head stability while stalled.
module tb_rcvr_deser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_sclk = 1'b0;
  logic        i_fs = 1'b0;
  logic        i_d = 1'b0;
  logic        i_rx_rdy = 1'b0;
  logic        i_ovf_clr = 1'b0;
  logic [15:0] o_rx_data;
  logic        o_rx_vld;
  logic        o_ovf;
  logic [7:0]  o_err_cnt;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic        stall_prev = 1'b0;
  logic [15:0] stall_data = 16'd0;
  logic        bp_done = 1'b0;

  rcvr_deser #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_sclk    (i_sclk),
    .i_fs      (i_fs),
    .i_d       (i_d),
    .o_rx_data (o_rx_data),
    .o_rx_vld  (o_rx_vld),
    .i_rx_rdy  (i_rx_rdy),
    .o_ovf     (o_ovf),
    .i_ovf_clr (i_ovf_clr),
    .o_err_cnt (o_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every accepted word against the scoreboard and check
  // the head stays put while the consumer stalls.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev <= 1'b0;
    end else begin
      if (o_rx_vld && stall_prev) check("stall_stable", o_rx_data, stall_data);
      if (o_rx_vld && i_rx_rdy) begin
        if (exp_q.size() == 0) check("sb_unexpected_word", exp_q.size(), 1);
        else check("rx_word", o_rx_data, exp_q.pop_front());
      end
      stall_prev <= o_rx_vld && !i_rx_rdy;
      stall_data <= o_rx_data;
    end
  end

  // All stimulus changes sit 2 ns after a clk rising edge; waits are whole clk periods.
  task automatic wait_clk(input int n);
    #(10 * n);
  endtask

  // One link sample: sclk high for 3 clk with fs/d set, then low for 3 clk.
  task automatic send_bit(input logic fs, input logic d);
    i_sclk = 1'b1;
    i_fs   = fs;
    i_d    = d;
    #30;
    i_sclk = 1'b0;
    #30;
  endtask

  task automatic send_word(input logic [15:0] w, input logic last_fs, input logic expect_it);
    if (expect_it) exp_q.push_back(w);
    for (int i = 15; i >= 0; i--) send_bit((i == 0) ? last_fs : 1'b0, w[i]);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      #10;
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #2;
    check("rst_vld", o_rx_vld, 0);
    check("rst_ovf", o_ovf, 0);
    check("rst_err", o_err_cnt, 0);
    check("rst_data", o_rx_data, 16'h0000);
    rst_n = 1'b1;
    wait_clk(2);

    // Single word, checked directly before the consumer is enabled
    send_bit(1'b1, 1'b0);
    send_word(16'hA5C3, 1'b0, 1'b1);
    check("single_vld", o_rx_vld, 1);
    check("single_data", o_rx_data, 16'hA5C3);
    i_rx_rdy = 1'b1;
    wait_drain(50);
    for (int i = 0; i < 20; i++) send_bit(1'b0, 1'b1);
    check("idle_no_word", o_rx_vld, 0);

    // Streaming, fs overlapped with the last bit
    send_bit(1'b1, 1'b0);
    send_word(16'h1234, 1'b1, 1'b1);
    send_word(16'h8001, 1'b1, 1'b1);
    send_word(16'hFFFF, 1'b0, 1'b1);
    wait_drain(50);
    check("stream_err", o_err_cnt, 0);

    // Framing error after 7 bits
    send_bit(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    send_word(16'h0F0F, 1'b0, 1'b1);
    wait_drain(50);
    check("frm_err_one", o_err_cnt, 1);

    // 300 more framing errors: counter saturates
    send_bit(1'b1, 1'b0);
    for (int r = 0; r < 300; r++) begin
      for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
    end
    send_word(16'h0F0F, 1'b0, 1'b1);
    wait_drain(50);
    check("frm_err_sat", o_err_cnt, 255);

    // Overflow: five words into a 4-deep FIFO with the consumer stalled
    i_rx_rdy = 1'b0;
    send_bit(1'b1, 1'b0);
    send_word(16'h0001, 1'b1, 1'b1);
    send_word(16'h0002, 1'b1, 1'b1);
    send_word(16'h0003, 1'b1, 1'b1);
    send_word(16'h0004, 1'b1, 1'b1);
    send_word(16'h0005, 1'b0, 1'b0);
    check("ovf_set", o_ovf, 1);
    i_rx_rdy = 1'b1;
    wait_drain(50);
    wait_clk(5);
    check("ovf_drained_vld", o_rx_vld, 0);
    check("ovf_sticky", o_ovf, 1);
    i_ovf_clr = 1'b1;
    wait_clk(1);
    i_ovf_clr = 1'b0;
    wait_clk(1);
    check("ovf_clr", o_ovf, 0);

    // Full FIFO: the fifth push lands on the same edge as a pop
    i_rx_rdy = 1'b0;
    send_bit(1'b1, 1'b0);
    send_word(16'h0011, 1'b1, 1'b1);
    send_word(16'h0012, 1'b1, 1'b1);
    send_word(16'h0013, 1'b1, 1'b1);
    send_word(16'h0014, 1'b1, 1'b1);
    exp_q.push_back(16'h0015);
    for (int i = 15; i >= 1; i--) send_bit(1'b0, 1'(16'h0015 >> i));
    i_sclk = 1'b1;
    i_fs   = 1'b0;
    i_d    = 1'b1;
    #30;
    i_sclk = 1'b0;
    #20;
    i_rx_rdy = 1'b1;
    #10;
    i_rx_rdy = 1'b0;
    check("full_pushpop_no_ovf", o_ovf, 0);
    i_rx_rdy = 1'b1;
    wait_drain(50);

    // Reset mid-word with a word queued and a nonzero error count
    i_rx_rdy = 1'b0;
    send_bit(1'b1, 1'b0);
    send_word(16'h5A5A, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    for (int i = 0; i < 9; i++) send_bit(1'b0, 1'b1);
    check("pre_rst_vld", o_rx_vld, 1);
    check("pre_rst_err", o_err_cnt, 255);
    #4;
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", o_rx_vld, 0);
    check("mid_rst_data", o_rx_data, 16'h0000);
    check("mid_rst_err", o_err_cnt, 0);
    check("mid_rst_ovf", o_ovf, 0);
    #5;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(2);
    for (int i = 0; i < 20; i++) send_bit(1'b0, 1'($urandom_range(0, 1)));
    check("post_rst_no_word", o_rx_vld, 0);
    i_rx_rdy = 1'b1;
    send_bit(1'b1, 1'b0);
    send_word(16'hBEEF, 1'b0, 1'b1);
    wait_drain(50);

    // Backpressure: 100 random streamed words with a random consumer
    bp_done = 1'b0;
    fork
      begin
        send_bit(1'b1, 1'b0);
        for (int k = 0; k < 100; k++)
          send_word(16'($urandom), (k != 99) ? 1'b1 : 1'b0, 1'b1);
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          i_rx_rdy = 1'($urandom_range(0, 1));
          #10;
        end
      end
    join
    i_rx_rdy = 1'b1;
    wait_drain(100);
    check("bp_no_ovf", o_ovf, 0);
    check("bp_no_err", o_err_cnt, 0);

    wait_clk(5);
    check("final_sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rcvr_deser.md
# rcvr_deser

Serial-to-parallel receiver for the frame-synced 16-bit serial link (fs / d / sclk) produced by the link transmitter. It oversamples the three link lines with the local clock, recovers 16-bit words MSB first, and delivers them through a small FIFO with a valid/ready handshake. Framing errors and FIFO overflow are reported to the control logic.

## Interface

Parameters:
- DEPTH, 4: output FIFO depth in words; power of two, minimum 2.

Ports:
- clk, input, 1: local clock.
- rst_n, input, 1: asynchronous, active-low reset.
- i_sclk, input, 1: link serial clock, asynchronous to clk; idles low.
- i_fs, input, 1: link frame sync, asynchronous.
- i_d, input, 1: link serial data, asynchronous.
- o_rx_data, output, 16: word at the FIFO head.
- o_rx_vld, output, 1: FIFO not empty.
- i_rx_rdy, input, 1: consumer accepts the head word.
- o_ovf, output, 1: sticky overflow flag.
- i_ovf_clr, input, 1: clears o_ovf.
- o_err_cnt, output, 8: saturating count of framing errors.

## Operation

- **Input synchronisation:** i_sclk, i_fs and i_d each pass through a 2-FF synchroniser. A third register on sclk provides falling-edge detection.
- **Sample event:** one per detected sclk falling edge. On that event, the synchronised fs and d are the sampled values.
- **State IDLE:**
  - A sample with fs=1 goes to DATA with bit_cnt=0.
  - A sample with fs=0 is ignored.
- **State DATA:** each sample shifts d into a 16-bit shift register, MSB first.
  - bit_cnt<15 and fs=0: bit_cnt increments.
  - bit_cnt<15 and fs=1 (framing error): the partial word is discarded, o_err_cnt increments (saturating at 255), and the receiver stays in DATA with bit_cnt=0. That sample counts as the new sync slot.
  - bit_cnt==15: the word {shift[14:0], d} is pushed to the FIFO.
    - fs=1 on this sample: back-to-back word. Stay in DATA, bit_cnt=0, so the next sample is bit 15 of the next word.
    - fs=0: go to IDLE.
- **FIFO:**
  - Push occurs on the same clk edge as the 16th sample.
  - Pop occurs when o_rx_vld && i_rx_rdy.
  - Simultaneous push and pop are both performed, including when full: the pop frees the slot, so no overflow.
  - A push when full and not popping drops the new word and sets o_ovf.
  - o_ovf stays set until i_ovf_clr=1. If i_ovf_clr=1 and a new overflow occur on the same edge, set wins.
- **Head word:** o_rx_data is the FIFO head, registered or RAM-read with zero-latency show-ahead. It is undefined when o_rx_vld=0.
- **Reset, asynchronous:**
  - All synchroniser stages go to 0.
  - State goes to IDLE, bit_cnt=0, FIFO empty.
  - Outputs: o_rx_vld=0, o_ovf=0, o_err_cnt=0, o_rx_data=0.
  - Reset mid-word discards the partial word. After release, reception resumes only at the next fs sample.

## Timing

- **Link constraints:**
  - sclk high and low phases are each at least 2 clk periods. The transmitter's sclk = clk/2 therefore requires a receiver clk at least 2x the transmitter clk.
  - fs and d change only at the sclk rising edge and are stable through the following falling edge plus 3 clk.
- **Sample latency:** 3 clk rising edges after the sclk falling edge (2 synchroniser stages plus 1 detect/act).
- **Word latency:** o_rx_vld rises on the clk edge following the push, i.e. at most 4 clk edges after the 16th sclk falling edge of the word when the FIFO was empty.
- **Handshake:**
  - o_rx_vld stays high until the word is popped.
  - o_rx_data is stable while o_rx_vld=1 and i_rx_rdy=0.
  - One pop per clk maximum.
- **Throughput:** one word per 16 sclk periods in streaming mode (fs overlapped with the last bit), with no gap words.
- o_err_cnt and o_ovf update on the clk edge of the offending sample or push.

## Test plan

- **Single word:** fs sample, then 16 bits of 0xA5C3, fs=0 on the last bit -> exactly one word 0xA5C3 with o_rx_vld; state returns to IDLE; further sclk without fs produces no words.
- **Streaming:** words 0x1234, 0x8001, 0xFFFF with fs=1 on each last bit (except the final word) -> three words in order, o_err_cnt=0, no extra words.
- **Framing error:** fs, then 7 bits, then fs=1, then 16 bits of 0x0F0F -> only 0x0F0F delivered, o_err_cnt=1. Repeat 300 times -> o_err_cnt holds at 255.
- **Overflow:** DEPTH=4, i_rx_rdy=0, five streamed words 1..5 -> o_ovf=1; releasing rdy yields 1,2,3,4 only. i_ovf_clr pulse -> o_ovf=0. Also full FIFO with push and pop on the same cycle -> no overflow.
- **Reset mid-word:** assert rst_n low after 9 bits -> all outputs return to reset values immediately. Post-reset bits without fs are ignored; the next fs plus 0xBEEF delivers 0xBEEF.
- **Backpressure:** random i_rx_rdy during a 100-word stream of random data (FIFO kept from overflowing) -> every word received once, in order, with o_rx_data stable while stalled.
